// File: rtl/cv32e40p_ft_pkg.sv
// Shared types and constants for the fault-tolerant EX-stage helpers.
// Used by the permanent-fault detector (optional decay: CV32E40P_PFD_DECAY_EN).
package cv32e40p_ft_pkg;

    typedef enum logic [1:0] {
        PFD_OK      = 2'd0,
        PFD_SUSPECT = 2'd1,
        PFD_FAULTY  = 2'd2
    } pfd_state_e;

    localparam int N_REPLICA = 4;
    localparam int BANK_ALU  = 0;
    localparam int BANK_MULT = 1;

endpackage

// File: rtl/cv32e40p_pfd_unit_ft.sv
// One replica's leaky-bucket mismatch counter and fault FSM.
// Decay of the counter on clean votes is compiled in only when
// CV32E40P_PFD_DECAY_EN is defined; otherwise the counter only climbs.
//
// state       | meaning
// ------------+----------------------------------------------------------
// PFD_OK      | counter is zero, replica trusted
// PFD_SUSPECT | counter non-zero but below THRESHOLD
// PFD_FAULTY  | THRESHOLD reached; sticky until clear or rst
module cv32e40p_pfd_unit_ft
    import cv32e40p_ft_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int THRESHOLD    = 4,
    parameter int DECAY_PERIOD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic eligible,
    input  logic mismatch,
    output logic faulty,
    output logic faulty_nxt,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);

    pfd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             rise_q, rise_d;

`ifdef CV32E40P_PFD_DECAY_EN
    localparam int               SUB_W    = $clog2(DECAY_PERIOD);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(DECAY_PERIOD - 1);

    logic [SUB_W-1:0] sub_q, sub_d;
`else
    logic unused_decay_period;
    assign unused_decay_period = (DECAY_PERIOD != 0);
`endif

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Next-state: clear wins, then mismatch, then (optionally) decay
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
`ifdef CV32E40P_PFD_DECAY_EN
        sub_d   = sub_q;
`endif
        if (clear) begin
            state_d = PFD_OK;
            cnt_d   = '0;
`ifdef CV32E40P_PFD_DECAY_EN
            sub_d   = '0;
`endif
        end else if (eligible && (state_q != PFD_FAULTY)) begin
            if (mismatch) begin
                cnt_d = cnt_inc;
`ifdef CV32E40P_PFD_DECAY_EN
                sub_d = '0;
`endif
                if (cnt_inc >= THR) begin
                    state_d = PFD_FAULTY;
                    rise_d  = 1'b1;
                end else begin
                    state_d = PFD_SUSPECT;
                end
            end else begin
`ifdef CV32E40P_PFD_DECAY_EN
                if (sub_q == SUB_LAST) begin
                    sub_d = '0;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = PFD_OK;
                        end
                    end
                end else begin
                    sub_d = sub_q + 1'b1;
                end
`endif
            end
        end
    end

    // State, counter and rise-pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PFD_OK;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
`ifdef CV32E40P_PFD_DECAY_EN
            sub_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
`ifdef CV32E40P_PFD_DECAY_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign faulty     = (state_q == PFD_FAULTY);
    assign faulty_nxt = (state_d == PFD_FAULTY);
    assign rise       = rise_q;

endmodule

// File: rtl/cv32e40p_perm_fault_detector_ft.sv
// Permanent-fault mask producer for the FT EX-stage dispatcher.
// Routes each TMR vote to the ALU or MULT bank, qualifies it per replica,
// and runs eight cv32e40p_pfd_unit_ft trackers. Optional counter decay is
// enabled by defining CV32E40P_PFD_DECAY_EN.
module cv32e40p_perm_fault_detector_ft
    import cv32e40p_ft_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int THRESHOLD    = 4,
    parameter int DECAY_PERIOD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_used_i,
    input  logic                 mult_used_i,
    input  logic                 vote_valid_i,
    input  logic [N_REPLICA-1:0] replica_mismatch_i,
    input  logic [N_REPLICA-1:0] clock_gate_pipe_replica_i,
    input  logic                 clear_i,
    output logic [N_REPLICA-1:0] permanent_faulty_alu_o,
    output logic [N_REPLICA-1:0] permanent_faulty_mult_o,
    output logic                 fault_event_o,
    output logic                 alu_all_faulty_o,
    output logic                 mult_all_faulty_o
);

    logic [1:0]           bank_sel;
    logic [N_REPLICA-1:0] elig [2];
    logic [N_REPLICA-1:0] faulty [2];
    logic [N_REPLICA-1:0] faulty_nxt [2];
    logic [N_REPLICA-1:0] rise [2];
    logic                 alu_all_q, mult_all_q;

    // ALU has priority when both units claim the vote
    assign bank_sel[BANK_ALU]  = alu_used_i;
    assign bank_sel[BANK_MULT] = ~alu_used_i & mult_used_i;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar k = 0; k < N_REPLICA; k++) begin : g_rep
            assign elig[b][k] = vote_valid_i & bank_sel[b]
                              & clock_gate_pipe_replica_i[k] & ~faulty[b][k];

            cv32e40p_pfd_unit_ft #(
                .CNT_W        (CNT_W),
                .THRESHOLD    (THRESHOLD),
                .DECAY_PERIOD (DECAY_PERIOD)
            ) u_unit (
                .clk        (clk),
                .rst        (rst),
                .clear      (clear_i),
                .eligible   (elig[b][k]),
                .mismatch   (replica_mismatch_i[k]),
                .faulty     (faulty[b][k]),
                .faulty_nxt (faulty_nxt[b][k]),
                .rise       (rise[b][k])
            );
        end
    end

    // All-faulty flags registered from next-state so they line up with the masks
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_all_q  <= 1'b0;
            mult_all_q <= 1'b0;
        end else begin
            alu_all_q  <= &faulty_nxt[BANK_ALU];
            mult_all_q <= &faulty_nxt[BANK_MULT];
        end
    end

    assign permanent_faulty_alu_o  = faulty[BANK_ALU];
    assign permanent_faulty_mult_o = faulty[BANK_MULT];
    assign fault_event_o           = |{rise[BANK_ALU], rise[BANK_MULT]};
    assign alu_all_faulty_o        = alu_all_q;
    assign mult_all_faulty_o       = mult_all_q;

endmodule

// File: tb/tb_cv32e40p_perm_fault_detector_ft.sv
// Directed bench for cv32e40p_perm_fault_detector_ft (THRESHOLD=4,
// DECAY_PERIOD=16). Expectations follow CV32E40P_PFD_DECAY_EN when defined.
module tb_cv32e40p_perm_fault_detector_ft;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_used_i, mult_used_i, vote_valid_i, clear_i;
    logic [3:0] replica_mismatch_i, clock_gate_pipe_replica_i;
    logic [3:0] permanent_faulty_alu_o, permanent_faulty_mult_o;
    logic       fault_event_o, alu_all_faulty_o, mult_all_faulty_o;

    int checks = 0;
    int errors = 0;

    cv32e40p_perm_fault_detector_ft #(
        .CNT_W(4), .THRESHOLD(4), .DECAY_PERIOD(16)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .alu_used_i                (alu_used_i),
        .mult_used_i               (mult_used_i),
        .vote_valid_i              (vote_valid_i),
        .replica_mismatch_i        (replica_mismatch_i),
        .clock_gate_pipe_replica_i (clock_gate_pipe_replica_i),
        .clear_i                   (clear_i),
        .permanent_faulty_alu_o    (permanent_faulty_alu_o),
        .permanent_faulty_mult_o   (permanent_faulty_mult_o),
        .fault_event_o             (fault_event_o),
        .alu_all_faulty_o          (alu_all_faulty_o),
        .mult_all_faulty_o         (mult_all_faulty_o)
    );

    always #5 clk = ~clk;

    // One vote applied at negedge, sampled 1 time unit after the next posedge
    task automatic vote(input logic a, input logic m, input logic [3:0] mm,
                        input logic [3:0] g);
        @(negedge clk);
        alu_used_i = a; mult_used_i = m; vote_valid_i = 1'b1;
        replica_mismatch_i = mm; clock_gate_pipe_replica_i = g;
        @(posedge clk); #1;
        alu_used_i = 1'b0; mult_used_i = 1'b0; vote_valid_i = 1'b0;
        replica_mismatch_i = 4'b0000;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        @(negedge clk); clear_i = 1'b1;
        @(posedge clk); #1; clear_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        checks++; if (permanent_faulty_alu_o !== 4'b0000) begin errors++;
            $display("FAIL reset_alu_mask got %b exp 0000", permanent_faulty_alu_o); end
        checks++; if (permanent_faulty_mult_o !== 4'b0000) begin errors++;
            $display("FAIL reset_mult_mask got %b exp 0000", permanent_faulty_mult_o); end
        checks++; if (fault_event_o !== 1'b0) begin errors++;
            $display("FAIL reset_event got %b exp 0", fault_event_o); end
        checks++; if ({alu_all_faulty_o, mult_all_faulty_o} !== 2'b00) begin errors++;
            $display("FAIL reset_all_faulty got %b exp 00", {alu_all_faulty_o, mult_all_faulty_o}); end
    endtask

    task automatic test_alu_threshold();
        for (int i = 0; i < 3; i++) begin
            vote(1'b1, 1'b0, 4'b0010, 4'b0111);
            checks++; if (permanent_faulty_alu_o !== 4'b0000 || fault_event_o !== 1'b0) begin errors++;
                $display("FAIL alu_pre_thr vote %0d mask %b ev %b exp 0000/0", i, permanent_faulty_alu_o, fault_event_o); end
        end
        vote(1'b1, 1'b0, 4'b0010, 4'b0111);
        checks++; if (permanent_faulty_alu_o !== 4'b0010) begin errors++;
            $display("FAIL alu_thr_mask got %b exp 0010", permanent_faulty_alu_o); end
        checks++; if (fault_event_o !== 1'b1) begin errors++;
            $display("FAIL alu_thr_event got %b exp 1", fault_event_o); end
        checks++; if (permanent_faulty_mult_o !== 4'b0000) begin errors++;
            $display("FAIL alu_thr_mult_mask got %b exp 0000", permanent_faulty_mult_o); end
        idle();
        checks++; if (fault_event_o !== 1'b0 || permanent_faulty_alu_o !== 4'b0010) begin errors++;
            $display("FAIL alu_thr_after ev %b mask %b exp 0/0010", fault_event_o, permanent_faulty_alu_o); end
        vote(1'b1, 1'b0, 4'b0010, 4'b0111);
        checks++; if (fault_event_o !== 1'b0 || permanent_faulty_alu_o !== 4'b0010) begin errors++;
            $display("FAIL alu_faulty_repeat ev %b mask %b exp 0/0010", fault_event_o, permanent_faulty_alu_o); end
        do_clear();
        checks++; if (permanent_faulty_alu_o !== 4'b0000) begin errors++;
            $display("FAIL alu_clear got %b exp 0000", permanent_faulty_alu_o); end
    endtask

    task automatic test_decay();
        logic [3:0] exp_after [3];
`ifdef CV32E40P_PFD_DECAY_EN
        exp_after[0] = 4'b0000; exp_after[1] = 4'b0000; exp_after[2] = 4'b0001;
`else
        exp_after[0] = 4'b0001; exp_after[1] = 4'b0001; exp_after[2] = 4'b0001;
`endif
        for (int i = 0; i < 3; i++) vote(1'b0, 1'b1, 4'b0001, 4'b1111);
        checks++; if (permanent_faulty_mult_o !== 4'b0000) begin errors++;
            $display("FAIL decay_pre got %b exp 0000", permanent_faulty_mult_o); end
        for (int i = 0; i < 32; i++) vote(1'b0, 1'b1, 4'b0000, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            vote(1'b0, 1'b1, 4'b0001, 4'b1111);
            checks++; if (permanent_faulty_mult_o !== exp_after[i]) begin errors++;
                $display("FAIL decay_mm%0d got %b exp %b", i, permanent_faulty_mult_o, exp_after[i]); end
        end
        checks++; if (permanent_faulty_alu_o !== 4'b0000) begin errors++;
            $display("FAIL decay_alu_mask got %b exp 0000", permanent_faulty_alu_o); end
        do_clear();
    endtask

    task automatic test_gated();
        for (int i = 0; i < 10; i++) vote(1'b1, 1'b0, 4'b1000, 4'b0111);
        checks++; if (permanent_faulty_alu_o !== 4'b0000 || fault_event_o !== 1'b0) begin errors++;
            $display("FAIL gated_mask got %b ev %b exp 0000/0", permanent_faulty_alu_o, fault_event_o); end
        for (int i = 0; i < 3; i++) vote(1'b1, 1'b0, 4'b1000, 4'b1111);
        checks++; if (permanent_faulty_alu_o !== 4'b0000) begin errors++;
            $display("FAIL gated_cnt_zero got %b exp 0000", permanent_faulty_alu_o); end
        vote(1'b1, 1'b0, 4'b1000, 4'b1111);
        checks++; if (permanent_faulty_alu_o !== 4'b1000) begin errors++;
            $display("FAIL gated_then_thr got %b exp 1000", permanent_faulty_alu_o); end
        do_clear();
    endtask

    task automatic test_both_used();
        for (int i = 0; i < 4; i++) vote(1'b1, 1'b1, 4'b0001, 4'b1111);
        checks++; if (permanent_faulty_alu_o !== 4'b0001) begin errors++;
            $display("FAIL both_alu got %b exp 0001", permanent_faulty_alu_o); end
        checks++; if (permanent_faulty_mult_o !== 4'b0000) begin errors++;
            $display("FAIL both_mult got %b exp 0000", permanent_faulty_mult_o); end
        do_clear();
    endtask

    task automatic test_all_faulty_clear();
        for (int i = 0; i < 4; i++) vote(1'b1, 1'b0, 4'b1111, 4'b1111);
        checks++; if (permanent_faulty_alu_o !== 4'b1111 || alu_all_faulty_o !== 1'b1) begin errors++;
            $display("FAIL all_alu mask %b all %b exp 1111/1", permanent_faulty_alu_o, alu_all_faulty_o); end
        checks++; if (fault_event_o !== 1'b1 || mult_all_faulty_o !== 1'b0) begin errors++;
            $display("FAIL all_event ev %b mult_all %b exp 1/0", fault_event_o, mult_all_faulty_o); end
        idle();
        checks++; if (fault_event_o !== 1'b0) begin errors++;
            $display("FAIL all_single_pulse got %b exp 0", fault_event_o); end
        @(negedge clk);
        clear_i = 1'b1; alu_used_i = 1'b1; vote_valid_i = 1'b1;
        replica_mismatch_i = 4'b1111; clock_gate_pipe_replica_i = 4'b1111;
        @(posedge clk); #1;
        clear_i = 1'b0; alu_used_i = 1'b0; vote_valid_i = 1'b0; replica_mismatch_i = 4'b0000;
        checks++; if (permanent_faulty_alu_o !== 4'b0000 || alu_all_faulty_o !== 1'b0 || fault_event_o !== 1'b0) begin errors++;
            $display("FAIL clear_mm mask %b all %b ev %b exp 0000/0/0", permanent_faulty_alu_o, alu_all_faulty_o, fault_event_o); end
        for (int i = 0; i < 3; i++) vote(1'b1, 1'b0, 4'b1111, 4'b1111);
        checks++; if (permanent_faulty_alu_o !== 4'b0000) begin errors++;
            $display("FAIL clear_cnt_zero got %b exp 0000", permanent_faulty_alu_o); end
        vote(1'b1, 1'b0, 4'b1111, 4'b1111);
        checks++; if (permanent_faulty_alu_o !== 4'b1111) begin errors++;
            $display("FAIL clear_rethr got %b exp 1111", permanent_faulty_alu_o); end
        do_clear();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) vote(1'b1, 1'b0, 4'b0100, 4'b1111);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 3; i++) vote(1'b1, 1'b0, 4'b0100, 4'b1111);
        checks++; if (permanent_faulty_alu_o !== 4'b0000) begin errors++;
            $display("FAIL rstmid_pre got %b exp 0000", permanent_faulty_alu_o); end
        vote(1'b1, 1'b0, 4'b0100, 4'b1111);
        checks++; if (permanent_faulty_alu_o !== 4'b0100 || fault_event_o !== 1'b1) begin errors++;
            $display("FAIL rstmid_thr mask %b ev %b exp 0100/1", permanent_faulty_alu_o, fault_event_o); end
    endtask

    initial begin
        rst = 1'b1; alu_used_i = 1'b0; mult_used_i = 1'b0; vote_valid_i = 1'b0;
        clear_i = 1'b0; replica_mismatch_i = 4'b0000; clock_gate_pipe_replica_i = 4'b1111;
        test_reset();
        test_alu_threshold();
        test_decay();
        test_gated();
        test_both_used();
        test_all_faulty_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
